gerador_imediato_pipeline: RTL
==============================

Name: gerador_imediato_pipeline

Overview:
Registered, handshaked immediate generator for the decode stage. It sits between fetch/decode and the operand mux. It generalises the combinational immediate generator in four ways:
- Covers all RV32I/RV64I base formats (R, I, S, B, U, J).
- Parametrised in XLEN.
- Flags illegal or unsupported encodings instead of emitting X.
- Counts illegal instructions.

A 2-entry skid buffer gives full throughput with a registered in_pronto.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; immediate is sign-extended to XLEN.
CONT_W, 16, width of the saturating illegal-instruction counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
in_valido  input  1  instrucao is valid this cycle.
in_pronto  output  1  block can accept; transfer when in_valido && in_pronto.
instrucao  input  32  raw instruction word.
out_valido  output  1  imediato/formato/ilegal valid.
out_pronto  input  1  consumer accepts; transfer when out_valido && out_pronto.
imediato  output  XLEN  decoded, sign-extended immediate.
formato  output  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal; 6 never produced.
ilegal  output  1  1 when formato==7.
limpa_cont  input  1  synchronous clear of cont_ilegal.
cont_ilegal  output  CONT_W  saturating count of illegal instructions accepted.

Behaviour:
Reset:
- Synchronous, active-high. While reset is high: out_valido=0, imediato=0, formato=0, ilegal=0, cont_ilegal=0, both buffer entries invalid, in_pronto=0.
- Reset mid-stream discards the held and skid entries with no output.

Decode (combinational on instrucao, captured at input handshake):
- instrucao[1:0] != 2'b11 → illegal (compressed unsupported).
- I-type, opcodes 0000011, 0010011, 1100111, 1110011; also 0011011 only when XLEN=64: imm = sext(instr[31:20]).
- S-type, opcode 0100011: imm = sext({instr[31:25], instr[11:7]}).
- B-type, opcode 1100011: imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- U-type, opcodes 0110111, 0010111: imm = sext({instr[31:12], 12'b0}); bit 31 sign-extends when XLEN=64.
- J-type, opcode 1101111: imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- R-type, opcode 0110011; also 0111011 only when XLEN=64: imm=0, formato=0, not illegal.
- Any other opcode, including *W opcodes when XLEN=32: formato=7, ilegal=1, imediato=0.

Buffering and handshake:
- Entries: main (drives outputs) and skid. in_pronto = !skid_valid && !reset, so it depends only on a register and reset.
- Accept with main empty, or main being consumed this cycle → load main; out_valido=1 the next cycle.
- Accept while main is held (out_valido && !out_pronto) → load skid; in_pronto drops the next cycle.
- Main consumed while skid is valid → skid moves to main, skid clears. An input cannot be accepted in that cycle, because in_pronto was 0.
- Latency is exactly 1 cycle from input handshake to out_valido when unstalled. Throughput is 1 per cycle. Order is strictly preserved; no drop, no duplicate.
- Outputs are stable while out_valido && !out_pronto.

Counter:
- cont_ilegal increments on the input handshake of an illegal instruction.
- Saturates at 2^CONT_W−1.
- limpa_cont has priority over a simultaneous increment (result 0).

Test Plan:
- XLEN=32, single beats, out_pronto=1: 0xFFF00093 (addi −1) → imediato 0xFFFFFFFF, formato 1, one cycle after accept. 0xFE112E23 (sw x1,−4(x2)) → 0xFFFFFFFC, formato 2. 0xFE000CE3 (beq −8) → 0xFFFFFFF8, formato 3.
- 0x123450B7 (lui) → 0x12345000, formato 4. 0x001000EF (jal +2048) → 0x00000800, formato 5. 0x00B50533 (add) → 0, formato 0. With XLEN=64, 0x800000B7 → 0xFFFFFFFF80000000.
- Illegal inputs: 0x00000000 → formato 7, ilegal 1, imediato 0, cont_ilegal 1. With XLEN=32, 0x0010809B (addiw) → illegal. With XLEN=64, same word → formato 1, imm 1.
- CONT_W=2: 5 illegal words → counter 1,2,3,3,3. Assert limpa_cont in the same cycle as an illegal accept → 0.
- Backpressure: stream 6 instructions with in_valido=1, out_pronto=0 for 3 cycles then 1:
  - exactly 2 accepted, then in_pronto=0;
  - outputs stable while stalled;
  - all 6 emerge in order, no gaps once out_pronto=1.
- Reset asserted with both entries full → next cycle out_valido=0, in_pronto=0. After deassert, in_pronto=1 and the held data never appears.

Source files
------------

// File: rtl/gerador_imediato_pipeline.sv
// rtl/gerador_imediato_pipeline.sv - registered, handshaked RV32I/RV64I immediate generator
// A main/skid entry pair keeps in_pronto a pure function of registers while sustaining one beat per cycle.
module gerador_imediato_pipeline #(
  parameter int XLEN   = 32,
  parameter int CONT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valido,
  output logic              in_pronto,
  input  logic [31:0]       instrucao,
  output logic              out_valido,
  input  logic              out_pronto,
  output logic [XLEN-1:0]   imediato,
  output logic [2:0]        formato,
  output logic              ilegal,
  input  logic              limpa_cont,
  output logic [CONT_W-1:0] cont_ilegal
);

  localparam bit       RV64    = (XLEN == 64);
  localparam bit [2:0] FMT_R   = 3'd0;
  localparam bit [2:0] FMT_I   = 3'd1;
  localparam bit [2:0] FMT_S   = 3'd2;
  localparam bit [2:0] FMT_B   = 3'd3;
  localparam bit [2:0] FMT_U   = 3'd4;
  localparam bit [2:0] FMT_J   = 3'd5;
  localparam bit [2:0] FMT_ILL = 3'd7;

  logic [31:0]       w_imm32;
  logic [XLEN-1:0]   w_imm;
  logic [2:0]        w_fmt;
  logic              w_in_fire;
  logic              w_main_free;

  logic              r_main_valid;
  logic [XLEN-1:0]   r_main_imm;
  logic [2:0]        r_main_fmt;
  logic              r_skid_valid;
  logic [XLEN-1:0]   r_skid_imm;
  logic [2:0]        r_skid_fmt;
  logic [CONT_W-1:0] r_cont;

  // Anything not matched below, including compressed words, stays illegal with a zero immediate.
  always_comb begin
    w_imm32 = '0;
    w_fmt   = FMT_ILL;
    if (instrucao[1:0] == 2'b11) begin
      case (instrucao[6:0])
        7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
          w_fmt   = FMT_I;
          w_imm32 = {{20{instrucao[31]}}, instrucao[31:20]};
        end
        7'b0011011: begin
          if (RV64) begin
            w_fmt   = FMT_I;
            w_imm32 = {{20{instrucao[31]}}, instrucao[31:20]};
          end
        end
        7'b0100011: begin
          w_fmt   = FMT_S;
          w_imm32 = {{20{instrucao[31]}}, instrucao[31:25], instrucao[11:7]};
        end
        7'b1100011: begin
          w_fmt   = FMT_B;
          w_imm32 = {{19{instrucao[31]}}, instrucao[31], instrucao[7],
                     instrucao[30:25], instrucao[11:8], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          w_fmt   = FMT_U;
          w_imm32 = {instrucao[31:12], 12'b0};
        end
        7'b1101111: begin
          w_fmt   = FMT_J;
          w_imm32 = {{11{instrucao[31]}}, instrucao[31], instrucao[19:12],
                     instrucao[20], instrucao[30:21], 1'b0};
        end
        7'b0110011: w_fmt = FMT_R;
        7'b0111011: begin
          if (RV64) w_fmt = FMT_R;
        end
        default: w_fmt = FMT_ILL;
      endcase
    end
  end

  assign w_imm       = XLEN'($signed(w_imm32));
  assign in_pronto   = !r_skid_valid && !reset;
  assign w_in_fire   = in_valido && in_pronto;
  assign w_main_free = !r_main_valid || out_pronto;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_imm   <= '0;
      r_main_fmt   <= FMT_R;
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_fmt   <= FMT_R;
    end else if (w_main_free) begin
      // The skid entry is older than anything on the input, so it always refills main first.
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_imm   <= r_skid_imm;
        r_main_fmt   <= r_skid_fmt;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_main_valid <= 1'b1;
        r_main_imm   <= w_imm;
        r_main_fmt   <= w_fmt;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
      r_skid_imm   <= w_imm;
      r_skid_fmt   <= w_fmt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || limpa_cont) begin
      r_cont <= '0;
    end else if (w_in_fire && (w_fmt == FMT_ILL) && (r_cont != '1)) begin
      r_cont <= r_cont + CONT_W'(1);
    end
  end

  assign out_valido  = r_main_valid;
  assign imediato    = r_main_imm;
  assign formato     = r_main_fmt;
  assign ilegal      = (r_main_fmt == FMT_ILL);
  assign cont_ilegal = r_cont;

endmodule
